mdu_seq: RTL and testbench



---
 rtl/mdu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: shift-add multiplier and restoring
// divider retiring one bit per cycle, with a one-cycle sign/width fix-up stage.
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_D   = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_W   = CW'(HALF - 1);
  localparam logic [CW-1:0]   CNT_Z   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  state_t            state_r;
  logic [2:0]        op_r;
  logic              word_r;
  logic [CW-1:0]     cnt_r;
  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic [XLEN:0]     rem_r;
  logic [XLEN-1:0]   dvd_r;
  logic [XLEN-1:0]   dvs_r;
  logic [XLEN-1:0]   quo_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic [XLEN-1:0]   result_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;

  logic            sgn_s, is_div_s, rsvd_s, bz_s, ovf_s, special_s;
  logic            a_neg_s, b_neg_s;
  logic [XLEN-1:0] ea_s, eb_s, min_s, a_mag_s, b_mag_s, aligned_s, spec_res_s;
  logic            ge_s;
  logic [XLEN-1:0] r_s, raw_s, fix_res_s;

  // Operand decode at acceptance: effective width, magnitudes and special cases.
  always_comb begin
    sgn_s    = (op == OP_DIV) || (op == OP_REM);
    is_div_s = (op != OP_MUL) && (op <= OP_REMU);
    rsvd_s   = (op > OP_REMU);
    if (word) begin
      ea_s  = sgn_s ? sext_half(a[HALF-1:0]) : {{HALF{1'b0}}, a[HALF-1:0]};
      eb_s  = sgn_s ? sext_half(b[HALF-1:0]) : {{HALF{1'b0}}, b[HALF-1:0]};
      min_s = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      ea_s  = a;
      eb_s  = b;
      min_s = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg_s = sgn_s & ea_s[XLEN-1];
    b_neg_s = sgn_s & eb_s[XLEN-1];
    a_mag_s = a_neg_s ? neg(ea_s) : ea_s;
    b_mag_s = b_neg_s ? neg(eb_s) : eb_s;
    // Word dividends are left-aligned so the iteration always consumes from the MSB.
    aligned_s = word ? {a_mag_s[HALF-1:0], {HALF{1'b0}}} : a_mag_s;
    bz_s      = is_div_s && (eb_s == ZERO);
    ovf_s     = sgn_s && (ea_s == min_s) && (eb_s == ONES);
    special_s = rsvd_s || bz_s || ovf_s;
    if (rsvd_s) begin
      spec_res_s = ZERO;
    end else if (bz_s) begin
      if ((op == OP_DIV) || (op == OP_DIVU)) begin
        spec_res_s = ONES;
      end else begin
        spec_res_s = word ? sext_half(a[HALF-1:0]) : a;
      end
    end else if (ovf_s) begin
      spec_res_s = (op == OP_DIV) ? ea_s : ZERO;
    end else begin
      spec_res_s = ZERO;
    end
  end

  // Restoring-divide step: rem_r holds the shifted trial remainder.
  always_comb begin
    ge_s = (rem_r >= {1'b0, dvs_r});
    if (ge_s) begin
      r_s = rem_r[XLEN-1:0] - dvs_r;
    end else begin
      r_s = rem_r[XLEN-1:0];
    end
  end

  // Final sign correction and word sign-extension.
  always_comb begin
    case (op_r)
      OP_MUL:  raw_s = acc_r[XLEN-1:0];
      OP_DIV:  raw_s = neg_q_r ? neg(quo_r) : quo_r;
      OP_DIVU: raw_s = quo_r;
      OP_REM:  raw_s = neg_r_r ? neg(rem_r[XLEN-1:0]) : rem_r[XLEN-1:0];
      OP_REMU: raw_s = rem_r[XLEN-1:0];
      default: raw_s = ZERO;
    endcase
    if (word_r) begin
      fix_res_s = sext_half(raw_s[HALF-1:0]);
    end else begin
      fix_res_s = raw_s;
    end
  end

  // Sequencer state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      word_r      <= 1'b0;
      cnt_r       <= CNT_Z;
      acc_r       <= {(2*XLEN){1'b0}};
      mcand_r     <= {(2*XLEN){1'b0}};
      mplier_r    <= ZERO;
      rem_r       <= {(XLEN+1){1'b0}};
      dvd_r       <= ZERO;
      dvs_r       <= ZERO;
      quo_r       <= ZERO;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      result_r    <= ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_Z;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            op_r       <= op;
            word_r     <= word;
            cnt_r      <= word ? CNT_W : CNT_D;
            acc_r      <= {(2*XLEN){1'b0}};
            mcand_r    <= {ZERO, ea_s};
            mplier_r   <= eb_s;
            rem_r      <= {ZERO, aligned_s[XLEN-1]};
            dvd_r      <= {aligned_s[XLEN-2:0], 1'b0};
            dvs_r      <= b_mag_s;
            quo_r      <= ZERO;
            neg_q_r    <= a_neg_s ^ b_neg_s;
            neg_r_r    <= a_neg_s;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (special_s) begin
              state_r     <= DONE;
              result_r    <= spec_res_s;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
          mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          quo_r    <= {quo_r[XLEN-2:0], ge_s};
          dvd_r    <= {dvd_r[XLEN-2:0], 1'b0};
          if (cnt_r == CNT_Z) begin
            rem_r   <= {1'b0, r_s};
            state_r <= FIX;
          end else begin
            rem_r <= {r_s, dvd_r[XLEN-1]};
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        FIX: begin
          result_r    <= fix_res_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed scoreboard bench for mdu_seq: expected results queued at issue,
// popped and compared when out_valid rises; latency and handshake checked too.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, word;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  int          cycles;
  logic        seen;
  logic [63:0] exp_q[$];

  mdu_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .word(word), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic start_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    op = o; word = w; a = x; b = y; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = o ^ 3'b001; word = ~w; a = ~x; b = ~y;
  endtask

  task automatic finish_op(input string tag, input int lat, input int hold);
    logic [63:0] expv;
    cycles = 1;
    while (!out_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_lat"}, 64'(cycles), 64'(lat));
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    chk({tag, "_res"}, result, expv);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 3'd0; a = 64'd3; b = 64'd5;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", result, expv);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drain"}, 64'({out_valid, in_ready, busy}), 64'b010);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic w, input logic [63:0] x,
                     input logic [63:0] y, input logic [63:0] expv, input int lat, input int hold);
    exp_q.push_back(expv);
    start_op(o, w, x, y);
    finish_op(tag, lat, hold);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    word = 1'b0; op = 3'd0; a = 64'd0; b = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_flags", 64'({out_valid, in_ready, busy}), 64'b010);
    chk("reset_result", result, 64'd0);

    run("divu",   3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0);
    run("remu",   3'd4, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);
    run("div_n",  3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, 0);
    run("rem_n",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run("divw",   3'd1, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34, 0);
    run("div_nb", 3'd1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run("rem_nb", 3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 0);
    run("divu_big", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66, 0);
    run("divuw_mask", 3'd2, 1'b1, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007, 64'd14, 34, 0);
    run("remw",   3'd3, 1'b1, 64'h0000_0000_FFFF_FF9B, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
    run("div_z",  3'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run("rem_z",  3'd3, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run("remuw_z", 3'd4, 1'b1, 64'h0000_0000_8000_0005, 64'h1234_5678_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, 0);
    run("div_ovf", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    run("rem_ovf", 3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run("divw_ovf", 3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run("rsvd",   3'd6, 1'b0, 64'd9, 64'd3, 64'd0, 1, 0);
    run("mul",    3'd0, 1'b0, 64'h1_2345_6789, 64'h10, 64'h12_3456_7890, 66, 0);
    run("mul_neg", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 66, 0);
    run("mulw",   3'd0, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, 0);
    run("bp",     3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 66, 5);

    // Flush during the eleventh BUSY iteration: nothing may come out.
    start_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    repeat (10) @(negedge clk);
    chk("flush_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_post", 64'({out_valid, in_ready, busy}), 64'b010);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run("after_flush", 3'd2, 1'b0, 64'd9, 64'd3, 64'd3, 66, 0);

    // Flush together with a request in IDLE: request is refused.
    op = 3'd2; word = 1'b0; a = 64'd9; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle", 64'({out_valid, in_ready, busy}), 64'b010);

    // Flush in DONE coincident with out_ready drops the result.
    start_op(3'd1, 1'b0, 64'd5, 64'd0);
    chk("flush_done_pre", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_post", 64'({out_valid, in_ready, busy}), 64'b010);

    // Reset in the middle of a multiply.
    start_op(3'd0, 1'b0, 64'd12345, 64'd678);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_flags", 64'({out_valid, in_ready, busy}), 64'b010);
    chk("reset_mid_result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
